// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pid_pkg
// Description : Shared widths, FSM/operand-select encodings and output
//               saturation helper for the PID compute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

    localparam int GAIN_W  = 6;
    localparam int DATA_W  = 8;
    localparam int ERR_W   = 9;
    localparam int DER_W   = 10;
    localparam int INT_W   = 12;
    localparam int ACC_W   = 20;
    localparam int MUL_A_W = GAIN_W + 1;
    localparam int PROD_W  = MUL_A_W + INT_W;

    localparam int c_ctl_min = 0;
    localparam int c_ctl_max = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_MUL_D = 3'd4,
        ST_OUT   = 3'd5
    } pid_state_t;

    typedef enum logic [1:0] {
        SEL_P = 2'd0,
        SEL_I = 2'd1,
        SEL_D = 2'd2
    } mac_sel_t;

    // Clamp a signed, already-scaled accumulator value into the 8-bit control range.
    function automatic logic [DATA_W-1:0] sat_control(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] v_lo;
        logic signed [ACC_W-1:0] v_hi;
        v_lo = ACC_W'(c_ctl_min);
        v_hi = ACC_W'(c_ctl_max);
        if (s < v_lo) begin
            return DATA_W'(c_ctl_min);
        end else if (s > v_hi) begin
            return DATA_W'(c_ctl_max);
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_mac.sv
`default_nettype none
// ============================================================================
// Module      : pid_mac
// Description : Single shared signed 7x12 multiplier with 20-bit accumulator,
//               time-multiplexed over the P, I and D terms.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_mac
    import pid_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     clear,
    input  logic                     accumulate,
    input  mac_sel_t                 sel,
    input  logic [GAIN_W-1:0]        k_p,
    input  logic [GAIN_W-1:0]        k_i,
    input  logic [GAIN_W-1:0]        k_d,
    input  logic signed [ERR_W-1:0]  err,
    input  logic signed [INT_W-1:0]  integ,
    input  logic signed [DER_W-1:0]  der,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [MUL_A_W-1:0] w_gain;
    logic signed [INT_W-1:0]   w_operand;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   r_acc;

    // Gains are unsigned, so a zero MSB makes them non-negative signed operands.
    always_comb begin
        w_gain    = '0;
        w_operand = '0;
        case (sel)
            SEL_P: begin
                w_gain    = {1'b0, k_p};
                w_operand = {{(INT_W-ERR_W){err[ERR_W-1]}}, err};
            end
            SEL_I: begin
                w_gain    = {1'b0, k_i};
                w_operand = integ;
            end
            SEL_D: begin
                w_gain    = {1'b0, k_d};
                w_operand = {{(INT_W-DER_W){der[DER_W-1]}}, der};
            end
            default: begin
                w_gain    = '0;
                w_operand = '0;
            end
        endcase
    end

    assign w_prod     = w_gain * w_operand;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (ena) begin
            if (clear) begin
                r_acc <= '0;
            end else if (accumulate) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pid_core.sv
`default_nettype none
// ============================================================================
// Module      : pid_core
// Description : Fixed-point PID stage producing one saturated 8-bit control
//               word per accepted sample, six cycles per sample.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_core
    import pid_pkg::*;
#(
    parameter int SHIFT   = 2,
    parameter int INT_MAX = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [GAIN_W-1:0] K_p,
    input  logic [GAIN_W-1:0] K_i,
    input  logic [GAIN_W-1:0] K_d,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic              sample_valid,
    output logic              busy,
    output logic [DATA_W-1:0] control,
    output logic              control_valid
);

    localparam logic signed [INT_W:0] c_int_hi = (INT_W+1)'(INT_MAX);
    localparam logic signed [INT_W:0] c_int_lo = -c_int_hi;

    pid_state_t r_state;
    pid_state_t w_next;

    logic [DATA_W-1:0]        r_sp;
    logic [DATA_W-1:0]        r_fb;
    logic [GAIN_W-1:0]        r_kp;
    logic [GAIN_W-1:0]        r_ki;
    logic [GAIN_W-1:0]        r_kd;
    // Holds the current error during the multiply phases and serves as e_prev for the next sample.
    logic signed [ERR_W-1:0]  r_err;
    logic signed [DER_W-1:0]  r_der;
    logic signed [INT_W-1:0]  r_integ;
    logic [DATA_W-1:0]        r_control;
    logic                     r_control_valid;

    logic                     w_busy;
    logic                     w_load;
    logic                     w_err_upd;
    logic                     w_mac_clear;
    logic                     w_mac_acc;
    mac_sel_t                 w_mac_sel;
    logic                     w_out;

    logic signed [ERR_W-1:0]  w_err;
    logic signed [DER_W-1:0]  w_der;
    logic signed [INT_W:0]    w_integ_sum;
    logic signed [INT_W-1:0]  w_integ_next;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (sample_valid) w_next = ST_ERR;
            ST_ERR:   w_next = ST_MUL_P;
            ST_MUL_P: w_next = ST_MUL_I;
            ST_MUL_I: w_next = ST_MUL_D;
            ST_MUL_D: w_next = ST_OUT;
            ST_OUT:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = 1'b1;
        w_load      = 1'b0;
        w_err_upd   = 1'b0;
        w_mac_clear = 1'b0;
        w_mac_acc   = 1'b0;
        w_mac_sel   = SEL_P;
        w_out       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                w_load = sample_valid;
            end
            ST_ERR: begin
                w_err_upd   = 1'b1;
                w_mac_clear = 1'b1;
            end
            ST_MUL_P: begin
                w_mac_acc = 1'b1;
                w_mac_sel = SEL_P;
            end
            ST_MUL_I: begin
                w_mac_acc = 1'b1;
                w_mac_sel = SEL_I;
            end
            ST_MUL_D: begin
                w_mac_acc = 1'b1;
                w_mac_sel = SEL_D;
            end
            ST_OUT: begin
                w_out = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign w_err       = $signed({1'b0, r_sp}) - $signed({1'b0, r_fb});
    assign w_der       = {w_err[ERR_W-1], w_err} - {r_err[ERR_W-1], r_err};
    assign w_integ_sum = {r_integ[INT_W-1], r_integ}
                       + {{(INT_W+1-ERR_W){w_err[ERR_W-1]}}, w_err};

    // Anti-windup: saturate, never wrap.
    always_comb begin
        w_integ_next = w_integ_sum[INT_W-1:0];
        if (w_integ_sum > c_int_hi) begin
            w_integ_next = c_int_hi[INT_W-1:0];
        end else if (w_integ_sum < c_int_lo) begin
            w_integ_next = c_int_lo[INT_W-1:0];
        end
    end

    assign w_shifted = w_acc >>> SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp            <= '0;
            r_fb            <= '0;
            r_kp            <= '0;
            r_ki            <= '0;
            r_kd            <= '0;
            r_err           <= '0;
            r_der           <= '0;
            r_integ         <= '0;
            r_control       <= '0;
            r_control_valid <= 1'b0;
        end else begin
            r_control_valid <= 1'b0;
            if (ena) begin
                if (w_load) begin
                    r_sp <= setpoint;
                    r_fb <= feedback;
                    r_kp <= K_p;
                    r_ki <= K_i;
                    r_kd <= K_d;
                end
                if (w_err_upd) begin
                    r_err   <= w_err;
                    r_der   <= w_der;
                    r_integ <= w_integ_next;
                end
                if (w_out) begin
                    r_control       <= sat_control(w_shifted);
                    r_control_valid <= 1'b1;
                end
            end
        end
    end

    pid_mac u_mac (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .clear      (w_mac_clear),
        .accumulate (w_mac_acc),
        .sel        (w_mac_sel),
        .k_p        (r_kp),
        .k_i        (r_ki),
        .k_d        (r_kd),
        .err        (r_err),
        .integ      (r_integ),
        .der        (r_der),
        .acc        (w_acc)
    );

    assign busy          = w_busy;
    assign control       = r_control;
    assign control_valid = r_control_valid;

endmodule
`default_nettype wire

// File: tb/tb_pid_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_core
// Description : Directed self-checking bench for pid_core with a per-sample
//               arithmetic reference model and hand-computed pins.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pid_core;

    localparam int SHIFT   = 2;
    localparam int INT_MAX = 2047;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [5:0] K_p = '0;
    logic [5:0] K_i = '0;
    logic [5:0] K_d = '0;
    logic [7:0] setpoint = '0;
    logic [7:0] feedback = '0;
    logic       sample_valid = 1'b0;
    logic       busy;
    logic [7:0] control;
    logic       control_valid;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    pid_core #(.SHIFT(SHIFT), .INT_MAX(INT_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .K_p           (K_p),
        .K_i           (K_i),
        .K_d           (K_d),
        .setpoint      (setpoint),
        .feedback      (feedback),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .control       (control),
        .control_valid (control_valid)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: whole-sample arithmetic plus a count of enabled cycles to completion.
    int m_integ   = 0;
    int m_eprev   = 0;
    int m_cnt     = 0;
    int m_pending = 0;
    int m_control = 0;
    int m_valid   = 0;

    function automatic int predict(input int sp, input int fb, input int kp, input int ki, input int kd);
        int e, d, acc, s;
        e = sp - fb;
        d = e - m_eprev;
        m_eprev = e;
        m_integ = m_integ + e;
        if (m_integ > INT_MAX)  m_integ = INT_MAX;
        if (m_integ < -INT_MAX) m_integ = -INT_MAX;
        acc = kp * e + ki * m_integ + kd * d;
        s = acc >>> SHIFT;
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_integ = 0; m_eprev = 0; m_cnt = 0; m_pending = 0; m_control = 0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (ena) begin
                if (m_cnt == 0) begin
                    if (sample_valid) begin
                        m_pending = predict(int'(setpoint), int'(feedback), int'(K_p), int'(K_i), int'(K_d));
                        m_cnt = 5;
                    end
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_control = m_pending;
                        m_valid = 1;
                    end
                end
            end
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_busy", int'(busy), int'(m_cnt != 0));
            check("cyc_valid", int'(control_valid), m_valid);
            check("cyc_control", int'(control), m_control);
        end
    end

    task automatic run(input string name, input int sp, input int fb, input int kp, input int ki,
                       input int kd, input int exp_ctl, input int exp_lat,
                       input int off_at = -1, input int off_len = 0,
                       input int restrobe_at = -1, input int kp_new_at = -1);
        int n;
        int got;
        setpoint = 8'(sp); feedback = 8'(fb);
        K_p = 6'(kp); K_i = 6'(ki); K_d = 6'(kd);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        n = 0;
        got = 0;
        while (n < 40) begin
            if (control_valid) begin
                got = 1;
                break;
            end
            if (off_at >= 0 && n == off_at) ena = 1'b0;
            if (off_at >= 0 && n == off_at + off_len) ena = 1'b1;
            if (restrobe_at >= 0 && n == restrobe_at) sample_valid = 1'b1;
            if (restrobe_at >= 0 && n == restrobe_at + 1) sample_valid = 1'b0;
            if (kp_new_at >= 0 && n == kp_new_at) K_p = 6'd63;
            @(negedge clk);
            n++;
        end
        ena = 1'b1;
        sample_valid = 1'b0;
        check({name, "_done"}, got, 1);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_control"}, int'(control), exp_ctl);
    endtask

    task automatic quiet(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (control_valid) pulses++;
        end
        check({name, "_no_extra_valid"}, pulses, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_control", int'(control), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(control_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        // Proportional: 4*40 >>> 2 = 40; negative error saturates to 0.
        run("p_pos", 100, 60, 4, 0, 0, 40, 5);
        run("p_neg", 0, 200, 4, 0, 0, 0, 5);

        // Handshake: dropped strobe, gain change mid-flight, ena freeze.
        run("restrobe", 100, 60, 4, 0, 0, 40, 5, -1, 0, 2, -1);
        quiet("restrobe", 8);
        run("kp_change", 100, 60, 4, 0, 0, 40, 5, -1, 0, -1, 1);
        run("freeze", 100, 60, 4, 0, 0, 40, 8, 2, 3, -1, -1);

        // Integral: integ 10,20,30 -> 2,5,7.
        pulse_reset();
        run("i_1", 10, 0, 0, 1, 0, 2, 5);
        run("i_2", 10, 0, 0, 1, 0, 5, 5);
        run("i_3", 10, 0, 0, 1, 0, 7, 5);

        // Abort a sample in flight; derivative must then see e_prev = 0.
        setpoint = 8'd50; feedback = 8'd0; K_p = '0; K_i = '0; K_d = 6'd8;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_control", int'(control), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(control_valid), 0);
        rst = 1'b0;
        quiet("midrst", 8);
        run("d_1", 20, 0, 0, 0, 8, 40, 5);
        run("d_2", 20, 0, 0, 0, 8, 0, 5);

        // Integral clamp at 2047, then unwinding from 1792 shows no wrap.
        pulse_reset();
        for (int k = 0; k < 10; k++) run("clamp_up", 255, 0, 0, 4, 0, 255, 5);
        run("clamp_down", 0, 255, 0, 4, 0, 255, 5);
        run("unwind_1", 0, 255, 0, 1, 0, 255, 5);
        run("unwind_2", 0, 255, 0, 1, 0, 255, 5);
        run("unwind_3", 0, 255, 0, 1, 0, 255, 5);
        run("unwind_4", 0, 255, 0, 1, 0, 193, 5);

        repeat (3) @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
